// File: rtl/machine_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : machine_rr_arbiter
// Description : Shares one combinational Machine datapath among NREQ
//               requesters. A round-robin grant selects a requester, and its
//               operand is registered and held on m_x. The Machine result is
//               captured and presented with the owning requester's index.
//               Only one transaction is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module machine_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic [1:0]        m_x,
  input  logic [1:0]        m_result,
  output logic              rsp_valid,
  output logic [1:0]        rsp_result,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);

  // IDLE: waiting for a request; EVAL: Machine sees the held operand;
  // RESP: result presented until the consumer accepts it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index of the last requester; the pointer wraps to 0 after it.
  localparam logic [IDW-1:0] c_last_idx = IDW'(NREQ - 1);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [1:0]      r_x;
  logic [1:0]      r_result;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_valid;

  logic            w_any;
  logic            w_found_hi;
  logic [IDW-1:0]  w_gidx_hi;
  logic [IDW-1:0]  w_gidx_lo;
  logic [IDW-1:0]  w_gidx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [1:0]      w_sel_x;
  logic            w_take;

  // Round-robin search. The scan ptr, ptr+1, ... with wrap-around is split
  // into two halves: the lowest valid index >= ptr wins if one exists,
  // otherwise the lowest valid index overall (which is then below ptr).
  // Iterating from the top down lets the lowest match be the last one written.
  always_comb begin
    w_any      = 1'b0;
    w_found_hi = 1'b0;
    w_gidx_hi  = '0;
    w_gidx_lo  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any     = 1'b1;
        w_gidx_lo = IDW'(i);
        if (IDW'(i) >= r_ptr) begin
          w_found_hi = 1'b1;
          w_gidx_hi  = IDW'(i);
        end
      end
    end
    w_gidx = w_found_hi ? w_gidx_hi : w_gidx_lo;
  end

  // A transfer happens only in IDLE, outside reset, with some request valid.
  assign w_take    = (r_state == ST_IDLE) && w_any && !rst;

  // The pointer moves one past the winner so the winner yields next time.
  assign w_ptr_nxt = (w_gidx == c_last_idx) ? '0 : (w_gidx + IDW'(1));

  // One-hot grant and operand mux for the selected requester.
  always_comb begin
    req_ready = '0;
    w_sel_x   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        req_ready[i] = w_take;
        w_sel_x      = req_x[2*i +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one evaluation cycle, then hold until accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand/owner capture on grant, result capture at the end of EVAL,
  // and response handshake. Reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_result    <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_x   <= w_sel_x;
            r_id  <= w_gidx;
            r_ptr <= w_ptr_nxt;
          end
        end
        ST_EVAL: begin
          r_result    <= m_result;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_x        = r_x;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_machine_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_machine_rr_arbiter
// Description : Scoreboard bench for machine_rr_arbiter. A reference model
//               predicts each grant from the round-robin rule and queues the
//               expected response; a monitor pops and compares responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_machine_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic [1:0]     m_x;
  logic [1:0]     m_result;
  logic           rsp_valid;
  logic [1:0]     rsp_result;
  logic [IDW-1:0] rsp_id;
  logic           rsp_ready;
  logic           busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [1:0] res;
    logic [1:0] x;
  } exp_t;

  exp_t sbq[$];

  // Model state: next search start, transaction phase (0 idle, 1 eval,
  // 2 resp), accept seen by the monitor, and "reset took effect last edge".
  int mptr        = 0;
  int phase       = 0;
  bit accept_seen = 1'b0;
  bit rst_applied = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the Machine datapath: a fixed bijection on 2 bits.
  function automatic logic [1:0] machine(input logic [1:0] x);
    case (x)
      2'd0:    return 2'd0;
      2'd1:    return 2'd3;
      2'd2:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  assign m_result = machine(m_x);

  machine_rr_arbiter #(.NREQ(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .m_x        (m_x),
    .m_result   (m_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester starting at p, wrapping modulo N; -1 if none.
  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: runs after the monitor in each low clock phase.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("rst_req_ready", req_ready, 0);
        if (rst_applied) begin
          check("rst_rsp_valid", rsp_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_m_x", m_x, 0);
        end
        sbq.delete();
        phase       = 0;
        mptr        = 0;
        accept_seen = 1'b0;
        rst_applied = 1'b1;
      end else begin
        if (rst_applied) begin
          check("post_rst_rsp_valid", rsp_valid, 0);
          check("post_rst_busy", busy, 0);
          check("post_rst_m_x", m_x, 0);
        end
        rst_applied = 1'b0;
        case (phase)
          0: begin
            int g;
            logic [N-1:0] oh;
            check("idle_busy", busy, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            g  = exp_grant(req_valid, mptr);
            oh = '0;
            if (g >= 0) oh[g] = 1'b1;
            check("grant", req_ready, oh);
            if (g >= 0) begin
              exp_t e;
              e.id  = g;
              e.x   = req_x[2*g +: 2];
              e.res = machine(e.x);
              sbq.push_back(e);
              mptr  = (g + 1) % N;
              phase = 1;
            end
          end
          1: begin
            check("eval_busy", busy, 1);
            check("eval_rsp_valid", rsp_valid, 0);
            check("eval_req_ready", req_ready, 0);
            if (sbq.size() > 0) check("eval_m_x", m_x, sbq[0].x);
            phase = 2;
          end
          default: begin
            check("resp_busy", busy, 1);
            check("resp_req_ready", req_ready, 0);
            check("resp_rsp_valid", rsp_valid, 1);
            if (accept_seen) phase = 0;
          end
        endcase
        accept_seen = 1'b0;
      end
    end
  end

  // Monitor: compares every presented response against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d result=%0d expected no response",
                   rsp_id, rsp_result);
        end else begin
          check("rsp_id", rsp_id, sbq[0].id);
          check("rsp_result", rsp_result, sbq[0].res);
          check("rsp_m_x", m_x, sbq[0].x);
          if (rsp_ready) begin
            void'(sbq.pop_front());
            accept_seen = 1'b1;
          end
        end
      end
    end
  end

  task automatic apply(input logic r, input logic [N-1:0] v, input logic [2*N-1:0] x,
                       input logic rd, input int n);
    rst       = r;
    req_valid = v;
    req_x     = x;
    rsp_ready = rd;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests pending.
    apply(1'b1, 4'b1111, 8'h00, 1'b0, 3);
    // Single request from requester 2 with x=3.
    apply(1'b0, 4'b0100, 8'b00_11_00_00, 1'b1, 1);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 4);
    // Round-robin from ptr=0 with every requester valid.
    apply(1'b1, 4'b0000, 8'h00, 1'b1, 1);
    apply(1'b0, 4'b1111, 8'b11_10_01_00, 1'b1, 15);
    // Backpressure while requests remain pending.
    apply(1'b0, 4'b1111, 8'h1B, 1'b0, 8);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 3);
    // Fairness between requesters 0 and 3.
    apply(1'b1, 4'b0000, 8'h00, 1'b1, 1);
    apply(1'b0, 4'b1001, 8'hC3, 1'b1, 12);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 3);
    // Reset while the response is waiting, then confirm ptr restarts at 0.
    apply(1'b0, 4'b0010, 8'h08, 1'b0, 1);
    apply(1'b0, 4'b0000, 8'h00, 1'b0, 2);
    apply(1'b1, 4'b0000, 8'h00, 1'b0, 1);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 2);
    apply(1'b0, 4'b1111, 8'h55, 1'b1, 1);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 3);
    // Reset during evaluation.
    apply(1'b0, 4'b1000, 8'hC0, 1'b1, 1);
    apply(1'b1, 4'b0000, 8'h00, 1'b1, 1);
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 2);
    // Randomized traffic with occasional resets and backpressure.
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 199) == 0), N'($urandom), (2*N)'($urandom),
            ($urandom_range(0, 3) != 0), 1);
    end
    apply(1'b0, 4'b0000, 8'h00, 1'b1, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
